// File: rtl/fifo_push_arb_pkg.sv
// Shared types and constants for the FIFO push-side round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_CNT_W = 32;

endpackage

// File: rtl/fifo_push_arb_if.sv
// Requester/FIFO push-side bundle; master is the arbiter, slave is the agent/FIFO side.
interface fifo_push_arb_if #(
  parameter int unsigned BUSW = 32,
  parameter int unsigned NREQ = 4
);
  import fifo_arb_pkg::*;

  localparam int unsigned OWN_W = $clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*BUSW-1:0] data;
  logic [NREQ-1:0]      gnt;
  logic                 push;
  logic                 full;
  logic [BUSW-1:0]      datain;
  logic [OWN_W-1:0]     arb_owner;
  logic                 arb_busy;
  logic [ARB_CNT_W-1:0] push_cnt;

  modport master (
    input  req, data, full,
    output gnt, push, datain, arb_owner, arb_busy, push_cnt
  );

  modport slave (
    output req, data, full,
    input  gnt, push, datain, arb_owner, arb_busy, push_cnt
  );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin finder: first set request bit above last_owner, wrapping.
module fifo_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic [$clog2(NREQ)-1:0] pick,
  output logic                    any
);

  localparam int unsigned OW = $clog2(NREQ);

  logic [OW-1:0] idx;

  // Scan offsets 1..NREQ so last_owner itself is considered last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(last_owner) + k) % NREQ);
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO push port between NREQ requesters, bursts of up to MAXBURST.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned BUSW     = 32,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAXBURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_push_arb_if.master bus
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAXBURST + 1);

  arb_state_e           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_owner_q, last_owner_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [ARB_CNT_W-1:0] push_cnt_q, push_cnt_d;

  logic [OW-1:0]   pick;
  logic            any;
  logic            own_req_c;
  logic            push_c;
  logic [BUSW-1:0] slice [NREQ];

  fifo_rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .pick       (pick),
    .any        (any)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = bus.data[g*BUSW +: BUSW];
  end

  // full gates push in the same cycle, so the FIFO can never overflow.
  assign own_req_c = bus.req[owner_q];
  assign push_c    = (state_q == OWN) && own_req_c && !bus.full;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    push_cnt_d   = push_cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = OWN;
        end
      end
      OWN: begin
        if (push_c) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          push_cnt_d = push_cnt_q + ARB_CNT_W'(1);
          if (beat_cnt_q == BW'(MAXBURST - 1)) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end
        end else if (!own_req_c) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      beat_cnt_q   <= '0;
      push_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      push_cnt_q   <= push_cnt_d;
    end
  end

  // datain is forced to zero off-transfer to keep the FIFO input X-free.
  always_comb begin
    bus.push   = push_c;
    bus.gnt    = '0;
    bus.datain = '0;
    if (push_c) begin
      bus.gnt[owner_q] = 1'b1;
      bus.datain       = slice[owner_q];
    end
  end

  assign bus.arb_owner = owner_q;
  assign bus.arb_busy  = (state_q == OWN);
  assign bus.push_cnt  = push_cnt_q;

endmodule

// File: tb/tb_fifo_push_arb.sv
// Bench for fifo_push_arb: directed vector table, reset-mid-burst sequence, randomized run vs. reference model.
module tb_fifo_push_arb;
  import fifo_arb_pkg::*;

  localparam int unsigned BUSW     = 32;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned MAXBURST = 4;
  localparam int unsigned OW       = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_push_arb_if #(.BUSW(BUSW), .NREQ(NREQ)) bus ();

  fifo_push_arb #(.BUSW(BUSW), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              rst_first;
    logic [NREQ-1:0] req;
    logic            full;
    logic [NREQ-1:0] gnt;
    int              owner;
    logic            busy;
    logic [BUSW-1:0] din;
    int              cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BUSW-1:0] tag(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic vec_t mk(input bit r, input logic [NREQ-1:0] rq, input logic fl,
                              input int own, input logic busy, input logic push, input int cnt);
    vec_t v;
    v.rst_first = r;
    v.req       = rq;
    v.full      = fl;
    v.owner     = own;
    v.busy      = busy;
    v.gnt       = push ? (NREQ'(1) << own) : '0;
    v.din       = push ? tag(own) : '0;
    v.cnt       = cnt;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst push", 64'(bus.push), 64'(0));
    check("rst gnt", 64'(bus.gnt), 64'(0));
    check("rst busy", 64'(bus.arb_busy), 64'(0));
    check("rst owner", 64'(bus.arb_owner), 64'(0));
    check("rst cnt", 64'(bus.push_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge: drive, let combinational paths settle, compare, move to next negedge.
  task automatic apply(input vec_t v, input int idx);
    bus.req  = v.req;
    bus.full = v.full;
    #2;
    check($sformatf("v%0d push", idx), 64'(bus.push), 64'(v.gnt != '0));
    check($sformatf("v%0d gnt", idx), 64'(bus.gnt), 64'(v.gnt));
    check($sformatf("v%0d busy", idx), 64'(bus.arb_busy), 64'(v.busy));
    check($sformatf("v%0d datain", idx), 64'(bus.datain), 64'(v.din));
    if (v.busy) check($sformatf("v%0d owner", idx), 64'(bus.arb_owner), 64'(v.owner));
    if (v.cnt >= 0) check($sformatf("v%0d cnt", idx), 64'(bus.push_cnt), 64'(v.cnt));
    @(negedge clk);
  endtask

  function automatic int rr_next(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= int'(NREQ); k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  initial begin
    logic [NREQ-1:0] rq, g_prev, e_gnt;
    logic [BUSW-1:0] dv [NREQ];
    logic [BUSW-1:0] e_din;
    logic            fl, e_push;
    int              m_owner, m_last, m_beats, run_len;
    bit              m_busy, run_live;
    logic [NREQ-1:0] run_gnt;
    logic [31:0]     m_cnt, obs_writes;
    vec_t            v;

    bus.req  = '0;
    bus.full = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) bus.data[i*BUSW +: BUSW] = tag(i);

    // Single requester: 4 beats, 1 idle, 4 beats, then push_cnt = 8.
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0));
    for (int j = 0; j < 4; j++) tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 1, j));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4));
    for (int j = 0; j < 4; j++) tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 1, 4 + j));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 8));
    // All requesting: owners 0,1,2,3,0 with 4 beats each.
    for (int b = 0; b < 5; b++) begin
      tbl.push_back(mk(b == 0, 4'b1111, 0, 0, 0, 0, b * 4));
      for (int j = 0; j < 4; j++) tbl.push_back(mk(0, 4'b1111, 0, b % 4, 1, 1, b * 4 + j));
    end
    // Owner 2 stalled by full for 5 cycles after 2 beats.
    tbl.push_back(mk(1, 4'b0100, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 2, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 2, 1, 1, 1));
    for (int j = 0; j < 5; j++) tbl.push_back(mk(0, 4'b0100, 1, 2, 1, 0, 2));
    tbl.push_back(mk(0, 4'b0100, 0, 2, 1, 1, 2));
    tbl.push_back(mk(0, 4'b0100, 0, 2, 1, 1, 3));
    tbl.push_back(mk(0, 4'b0100, 0, 2, 0, 0, 4));
    // Owner 1 drops req after one beat while requester 3 waits.
    tbl.push_back(mk(1, 4'b1010, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 3, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 3, 1, 1, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 3, 1, 1, 2));

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      apply(tbl[i], i);
    end

    // Asynchronous reset between edges during a burst.
    do_reset();
    apply(mk(0, 4'b0011, 0, 0, 0, 0, 0), 900);
    apply(mk(0, 4'b0011, 0, 0, 1, 1, 0), 901);
    #2;
    check("pre-rst push", 64'(bus.push), 64'(1));
    check("pre-rst cnt", 64'(bus.push_cnt), 64'(1));
    rst = 1'b1;
    #1;
    check("async push", 64'(bus.push), 64'(0));
    check("async gnt", 64'(bus.gnt), 64'(0));
    check("async busy", 64'(bus.arb_busy), 64'(0));
    check("async cnt", 64'(bus.push_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 4'b0011, 0, 0, 0, 0, 0), 902);
    apply(mk(0, 4'b0011, 0, 0, 1, 1, 0), 903);

    // Randomized run against the reference model.
    bus.req = '0;
    do_reset();
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0; m_cnt = '0;
    obs_writes = '0; run_len = 0; run_live = 0; run_gnt = '0;
    rq = '0; g_prev = '0;
    for (int i = 0; i < int'(NREQ); i++) dv[i] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // A waiting requester keeps req and data until it is granted.
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!(rq[i] && !g_prev[i])) begin
          rq[i] = ($urandom_range(0, 99) < 55);
          dv[i] = $urandom;
        end
      end
      fl = ($urandom_range(0, 99) < 25);
      bus.req  = rq;
      bus.full = fl;
      for (int i = 0; i < int'(NREQ); i++) bus.data[i*BUSW +: BUSW] = dv[i];
      #2;
      e_push = m_busy && rq[m_owner] && !fl;
      e_gnt  = e_push ? (NREQ'(1) << m_owner) : '0;
      e_din  = e_push ? dv[m_owner] : '0;
      check("rnd push", 64'(bus.push), 64'(e_push));
      check("rnd gnt", 64'(bus.gnt), 64'(e_gnt));
      check("rnd datain", 64'(bus.datain), 64'(e_din));
      check("rnd busy", 64'(bus.arb_busy), 64'(m_busy));
      check("rnd cnt", 64'(bus.push_cnt), 64'(m_cnt));
      if (m_busy) check("rnd owner", 64'(bus.arb_owner), 64'(m_owner));
      check("rnd push&full", 64'(bus.push & bus.full), 64'(0));
      check("rnd gnt onehot", 64'($countones(bus.gnt) <= 1), 64'(1));
      if (bus.push) begin
        run_len  = (run_live && bus.gnt == run_gnt) ? run_len + 1 : 1;
        run_gnt  = bus.gnt;
        run_live = 1;
        obs_writes++;
        check("rnd burst len", 64'(run_len <= int'(MAXBURST)), 64'(1));
      end
      if (!bus.arb_busy) run_live = 0;
      // Reference: what the arbiter should decide at the coming edge.
      if (!m_busy) begin
        if (rq != '0) begin
          m_owner = rr_next(m_last, rq);
          m_busy  = 1;
          m_beats = 0;
        end
      end else if (e_push) begin
        m_beats++;
        m_cnt++;
        if (m_beats == int'(MAXBURST)) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end else if (!rq[m_owner]) begin
        m_busy = 0;
        m_last = m_owner;
      end
      g_prev = e_gnt;
      @(negedge clk);
    end
    check("rnd writes vs cnt", 64'(bus.push_cnt), 64'(obs_writes));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
